// File: rtl/assoc_cache.sv
// assoc_cache: fully-associative, one-word-per-line cache with true-LRU
// replacement, between a ready/valid request port and a req/ack backing memory.
//
// Ports:
//   clk, clr                 clock (rising edge), async active-high reset
//   req_valid/req_ready      request handshake; ready only while IDLE
//   req_rw/req_addr/req_wdata   request fields, latched on accept
//   resp_valid               one-cycle completion pulse (reads and writes)
//   resp_rdata/resp_hit      read data (held until next response) and hit flag
//   mem_req/mem_rw/mem_addr/mem_wdata, mem_ack/mem_rdata   backing memory
//   state                    FSM state (IDLE=0 LOOKUP=1 MEMWR=2 FILL=3 EVICT=4 RESP=5)
//   lru_way                  current victim way
//
// Build option: ASSOC_CACHE_WRITE_BACK_EN selects write-back / write-allocate
// with per-way dirty bits. Undefined: write-through, no-write-allocate.
module assoc_cache #(
  parameter  int ADDR_W = 8,
  parameter  int DATA_W = 8,
  parameter  int WAYS   = 4,
  localparam int AGE_W  = $clog2(WAYS)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  output logic              mem_req,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        state,
  output logic [AGE_W-1:0]  lru_way
);

  typedef enum logic [2:0] {
    IDLE = 3'd0, LOOKUP = 3'd1, MEMWR = 3'd2, FILL = 3'd3, EVICT = 3'd4, RESP = 3'd5
  } state_t;

  typedef logic [WAYS-1:0][AGE_W-1:0] age_t;

  state_t                        state_q, state_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;
  logic [DATA_W-1:0]             wdata_q, wdata_d;
  logic                          rw_q, rw_d;
  logic                          wr_hit_q, wr_hit_d;
  logic [DATA_W-1:0]             rdata_q, rdata_d;
  logic                          hit_q, hit_d;
  logic [WAYS-1:0]               valid_q, valid_d;
  logic [WAYS-1:0][ADDR_W-1:0]   tag_q, tag_d;
  logic [WAYS-1:0][DATA_W-1:0]   data_q, data_d;
  age_t                          age_q, age_d;
`ifdef ASSOC_CACHE_WRITE_BACK_EN
  logic [WAYS-1:0]               dirty_q, dirty_d;
`endif

  logic             hit;
  logic [AGE_W-1:0] hit_way;
  logic [AGE_W-1:0] victim;
  logic             found;

  // Touch way w: it becomes youngest, every way younger than it ages by one,
  // so ages remain a permutation of 0..WAYS-1.
  function automatic age_t lru_touch(input age_t a, input logic [AGE_W-1:0] w);
    age_t r;
    r = a;
    for (int i = 0; i < WAYS; i++) begin
      if (AGE_W'(i) == w)  r[i] = '0;
      else if (a[i] < a[w]) r[i] = a[i] + 1'b1;
    end
    return r;
  endfunction

  // Tag compare against the latched address; first match wins (tags are unique).
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (valid_q[i] && tag_q[i] == addr_q && !hit) begin
        hit     = 1'b1;
        hit_way = AGE_W'(i);
      end
    end
  end

  // Victim: lowest invalid way, else the oldest line.
  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (!valid_q[i] && !found) begin
        victim = AGE_W'(i);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int i = 0; i < WAYS; i++) begin
        if (age_q[i] == AGE_W'(WAYS-1)) victim = AGE_W'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rw_d     = rw_q;
    wr_hit_d = wr_hit_q;
    rdata_d  = rdata_q;
    hit_d    = hit_q;
    valid_d  = valid_q;
    tag_d    = tag_q;
    data_d   = data_q;
    age_d    = age_q;
`ifdef ASSOC_CACHE_WRITE_BACK_EN
    dirty_d  = dirty_q;
`endif
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d  = req_addr;
        wdata_d = req_wdata;
        rw_d    = req_rw;
        state_d = LOOKUP;
      end
      LOOKUP: begin
        if (!rw_q) begin
          if (hit) begin
            rdata_d = data_q[hit_way];
            hit_d   = 1'b1;
            age_d   = lru_touch(age_q, hit_way);
            state_d = RESP;
          end else begin
            state_d = FILL;
`ifdef ASSOC_CACHE_WRITE_BACK_EN
            if (valid_q[victim] && dirty_q[victim]) state_d = EVICT;
`endif
          end
        end else begin
`ifdef ASSOC_CACHE_WRITE_BACK_EN
          if (hit) begin
            data_d[hit_way]  = wdata_q;
            dirty_d[hit_way] = 1'b1;
            age_d            = lru_touch(age_q, hit_way);
            hit_d            = 1'b1;
            state_d          = RESP;
          end else if (valid_q[victim] && dirty_q[victim]) begin
            state_d = EVICT;
          end else begin
            // A line is one word, so a write miss allocates without a fill.
            tag_d[victim]   = addr_q;
            data_d[victim]  = wdata_q;
            valid_d[victim] = 1'b1;
            dirty_d[victim] = 1'b1;
            age_d           = lru_touch(age_q, victim);
            hit_d           = 1'b0;
            state_d         = RESP;
          end
`else
          if (hit) begin
            data_d[hit_way] = wdata_q;
            age_d           = lru_touch(age_q, hit_way);
          end
          wr_hit_d = hit;
          state_d  = MEMWR;
`endif
        end
      end
      MEMWR: if (mem_ack) begin
        hit_d   = wr_hit_q;
        state_d = RESP;
      end
      FILL: if (mem_ack) begin
        tag_d[victim]   = addr_q;
        data_d[victim]  = mem_rdata;
        valid_d[victim] = 1'b1;
`ifdef ASSOC_CACHE_WRITE_BACK_EN
        dirty_d[victim] = 1'b0;
`endif
        age_d           = lru_touch(age_q, victim);
        rdata_d         = mem_rdata;
        hit_d           = 1'b0;
        state_d         = RESP;
      end
      // Re-enter LOOKUP after a writeback: the now-clean victim is picked again,
      // and mem_req gets its mandatory idle cycle before the next access.
      EVICT: if (mem_ack) begin
`ifdef ASSOC_CACHE_WRITE_BACK_EN
        dirty_d[victim] = 1'b0;
`endif
        state_d = LOOKUP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory outputs decode straight from state so reset drops mem_req at once.
  always_comb begin
    mem_req   = 1'b0;
    mem_rw    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      FILL:  begin mem_req = 1'b1; mem_addr = addr_q; end
      MEMWR: begin mem_req = 1'b1; mem_rw = 1'b1; mem_addr = addr_q; mem_wdata = wdata_q; end
      EVICT: begin mem_req = 1'b1; mem_rw = 1'b1; mem_addr = tag_q[victim]; mem_wdata = data_q[victim]; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rw_q     <= 1'b0;
      wr_hit_q <= 1'b0;
      rdata_q  <= '0;
      hit_q    <= 1'b0;
      valid_q  <= '0;
      tag_q    <= '0;
      data_q   <= '0;
      for (int i = 0; i < WAYS; i++) age_q[i] <= AGE_W'(i);
`ifdef ASSOC_CACHE_WRITE_BACK_EN
      dirty_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rw_q     <= rw_d;
      wr_hit_q <= wr_hit_d;
      rdata_q  <= rdata_d;
      hit_q    <= hit_d;
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      data_q   <= data_d;
      age_q    <= age_d;
`ifdef ASSOC_CACHE_WRITE_BACK_EN
      dirty_q  <= dirty_d;
`endif
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_hit   = hit_q;
  assign state      = state_q;
  assign lru_way    = victim;

endmodule

// File: tb/tb_assoc_cache.sv
// Scoreboard bench for assoc_cache (default parameters). Stimulus pushes the
// expected response and expected memory operations; monitors pop and compare.
module tb_assoc_cache;
  logic       clk = 1'b0, clr = 1'b1;
  logic       req_valid = 1'b0, req_ready, req_rw = 1'b0;
  logic [7:0] req_addr = '0, req_wdata = '0;
  logic       resp_valid, resp_hit;
  logic [7:0] resp_rdata;
  logic       mem_req, mem_rw, mem_ack = 1'b0;
  logic [7:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [2:0] state;
  logic [1:0] lru_way;

  assoc_cache dut (
    .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_hit(resp_hit), .mem_req(mem_req), .mem_rw(mem_rw),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .state(state), .lru_way(lru_way)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] rdata; logic hit; logic chk_rd; int lat; int acc; } exp_t;
  typedef struct { logic rw; logic [7:0] addr; logic [7:0] wdata; } mop_t;
  exp_t sb[$];
  mop_t exp_mem[$];

  int         n_chk = 0, n_fail = 0, cyc = 0;
  int         mem_dly = 3;
  bit         ack_hold = 1'b0;
  logic [7:0] mem_model [256];
  logic [7:0] exp_r1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever begin @(posedge clk); cyc++; end

  // Backing memory: acks mem_dly negedges after a request appears.
  initial begin
    int wc = 0;
    forever begin
      @(negedge clk);
      if (ack_hold) begin
        mem_ack = 1'b1; wc = 0;
      end else begin
        mem_ack = 1'b0;
        if (mem_req) begin
          if (wc == mem_dly) begin
            mem_ack = 1'b1;
            mem_rdata = mem_model[mem_addr];
            if (mem_rw) mem_model[mem_addr] = mem_wdata;
            wc = 0;
          end else wc++;
        end else wc = 0;
      end
    end
  end

  // Response monitor.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!clr && resp_valid) begin
      if (sb.size() == 0) chk("resp_unexpected", {31'd0, resp_valid}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("resp_hit", {31'd0, resp_hit}, {31'd0, e.hit});
        if (e.chk_rd) chk("resp_rdata", {24'd0, resp_rdata}, {24'd0, e.rdata});
        if (e.lat != 0) chk("hit_latency", cyc - e.acc, e.lat);
      end
    end
  end

  // Memory-request monitor: each new request must match the next expected op
  // and its address/data must hold until acked.
  initial begin
    mop_t m;
    logic prev = 1'b0;
    logic [7:0] pa = '0, pd = '0;
    forever begin
      @(negedge clk);
      if (mem_req && !prev) begin
        if (exp_mem.size() == 0) chk("mem_unexpected", {31'd0, mem_req}, 32'd0);
        else begin
          m = exp_mem.pop_front();
          chk("mem_rw", {31'd0, mem_rw}, {31'd0, m.rw});
          chk("mem_addr", {24'd0, mem_addr}, {24'd0, m.addr});
          if (m.rw) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, m.wdata});
        end
      end else if (mem_req) begin
        chk("mem_addr_stable", {24'd0, mem_addr}, {24'd0, pa});
        chk("mem_wdata_stable", {24'd0, mem_wdata}, {24'd0, pd});
      end
      prev = mem_req; pa = mem_addr; pd = mem_wdata;
    end
  end

  task automatic issue(input logic rw, input logic [7:0] a, input logic [7:0] wd,
                       input logic [7:0] rd, input logic hit, input logic chk_rd,
                       input int lat, input bit push);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
    req_rw = rw; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    if (push) sb.push_back('{rd, hit, chk_rd, lat, cyc});
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_rw = 1'b0;
  endtask

  task automatic wait_resp();
    for (int n = 0; n < 300 && sb.size() != 0; n++) begin @(negedge clk); #1; end
    if (sb.size() != 0) begin
      chk("resp_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input logic hit);
    if (!hit) exp_mem.push_back('{1'b0, a, 8'h00});
    issue(1'b0, a, 8'h00, exp, hit, 1'b1, hit ? 2 : 0, 1'b1);
    wait_resp();
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic hit, input bit mem);
    if (mem) exp_mem.push_back('{1'b1, a, d});
    issue(1'b1, a, d, 8'h00, hit, 1'b0, 0, 1'b1);
    wait_resp();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;
    mem_model[1] = 8'hE0; mem_model[2] = 8'h22; mem_model[3] = 8'h33;
    mem_model[4] = 8'h44; mem_model[7] = 8'h77; mem_model[8] = 8'h88;
    mem_model[9] = 8'h99; mem_model[5] = 8'h55;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", {24'd0, resp_rdata}, 32'd0);
    chk("rst_resp_hit", {31'd0, resp_hit}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_rw", {31'd0, mem_rw}, 32'd0);
    chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_lru_way", {30'd0, lru_way}, 32'd0);
    clr = 1'b0;

    // Miss then hit on 0x01.
    rd(8'h01, 8'hE0, 1'b0);
    rd(8'h01, 8'hE0, 1'b1);

    // Fill all ways, touch 0x01, then 0x02 is the LRU victim.
    rd(8'h02, 8'h22, 1'b0);
    rd(8'h03, 8'h33, 1'b0);
    rd(8'h04, 8'h44, 1'b0);
    rd(8'h01, 8'hE0, 1'b1);
    @(negedge clk);
    chk("lru_way_before_miss", {30'd0, lru_way}, 32'd1);
    rd(8'h07, 8'h77, 1'b0);
    rd(8'h02, 8'h22, 1'b0);
    rd(8'h01, 8'hE0, 1'b1);

    // Reset mid-fill: transaction abandoned, no response.
    mem_dly = 10;
    exp_mem.push_back('{1'b0, 8'h09, 8'h00});
    issue(1'b0, 8'h09, 8'h00, 8'h00, 1'b0, 1'b0, 0, 1'b0);
    repeat (5) @(negedge clk);
    chk("pre_clr_mem_req", {31'd0, mem_req}, 32'd1);
    clr = 1'b1; #1;
    chk("clr_mem_req", {31'd0, mem_req}, 32'd0);
    chk("clr_req_ready", {31'd0, req_ready}, 32'd1);
    chk("clr_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("clr_state", {29'd0, state}, 32'd0);
    @(negedge clk); clr = 1'b0;
    repeat (12) @(negedge clk);
    mem_dly = 3;
    rd(8'h01, 8'hE0, 1'b0);   // lines were invalidated

`ifdef ASSOC_CACHE_WRITE_BACK_EN
    // Write hit on 0x01, allocate 0x02..0x04, no memory traffic.
    wr(8'h01, 8'hA1, 1'b1, 1'b0);
    wr(8'h02, 8'hA2, 1'b0, 1'b0);
    wr(8'h03, 8'hA3, 1'b0, 1'b0);
    wr(8'h04, 8'hA4, 1'b0, 1'b0);
    // Dirty victim 0x01 is written back before 0x08 is filled.
    exp_mem.push_back('{1'b1, 8'h01, 8'hA1});
    rd(8'h08, 8'h88, 1'b0);
    exp_r1 = 8'hA1;
`else
    // Write miss goes to memory only; write hit updates both.
    wr(8'h05, 8'h18, 1'b0, 1'b1);
    rd(8'h05, 8'h18, 1'b0);
    wr(8'h01, 8'hC7, 1'b1, 1'b1);
    rd(8'h01, 8'hC7, 1'b1);
    exp_r1 = 8'hC7;
`endif
    chk("mem_model_01", {24'd0, mem_model[1]}, {24'd0, exp_r1});

    // mem_ack held high while idle is ignored.
    ack_hold = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      chk("ack_idle_state", {29'd0, state}, 32'd0);
      chk("ack_idle_resp", {31'd0, resp_valid}, 32'd0);
    end
    ack_hold = 1'b0;
    repeat (3) @(negedge clk);

    chk("mem_ops_drained", exp_mem.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/assoc_cache.md
Name: assoc_cache

Overview:
- Parametrised fully-associative cache with true-LRU replacement, one word per line.
- Sits between a processor-side request port and a slower backing memory with a req/ack handshake.
- Successor to the fixed 4-entry, 8-bit cache: width, depth and write policy are generalised.
- Adds a proper ready/valid front end and a stall-tolerant memory interface.

Parameters:
- ADDR_W, 8, address width (tag = full address).
- DATA_W, 8, data word width.
- WAYS, 4, number of lines; power of two, 2..16.
- AGE_W, $clog2(WAYS), LRU age counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts request; high only in IDLE.
- req_rw  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  one-cycle completion pulse, for reads and writes.
- resp_rdata  out  DATA_W  read data; held until next resp_valid.
- resp_hit  out  1  request hit the cache; valid with resp_valid.
- mem_req  out  1  backing-memory request.
- mem_rw  out  1  1 = write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  memory done; for reads, mem_rdata valid this cycle.
- mem_rdata  in  DATA_W  memory read data.
- state  out  3  FSM state, for debug.
- lru_way  out  AGE_W  current victim way index.

Behaviour:
- Reset (clr=1, async): all valid bits 0; age[i]=i; FSM to IDLE. Outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_hit=0, mem_req=0, mem_rw=0, mem_addr=0, mem_wdata=0. Reset mid-transaction abandons it; mem_req drops immediately.
- Request is accepted on the edge where req_valid && req_ready. Address, data and rw are latched; req_inputs are don't-care afterwards.
- FSM encoding: IDLE=0, LOOKUP=1, MEMWR=2, FILL=3, EVICT=4, RESP=5.
- IDLE -> LOOKUP on accept.
- LOOKUP: parallel tag compare over valid ways.
  - Read hit: -> RESP with way data; total latency = accept edge + 2 edges.
  - Read miss: -> FILL.
  - Write: see write policy.
- Victim selection: lowest-index invalid way if any; otherwise the way with age == WAYS-1. lru_way reflects this combinationally.
- LRU update on every hit or allocation of way w with prior age a: age[w]=0; every way with age < a increments. Ages stay a permutation of 0..WAYS-1.
- FILL: mem_req=1, mem_rw=0, mem_addr=latched addr. On mem_ack: write mem_rdata to victim, set valid, update LRU, -> RESP with resp_hit=0.
- Memory handshake:
  - mem_req and mem_addr/mem_wdata/mem_rw are held stable until mem_ack is sampled high.
  - mem_req is 0 in the cycle after ack.
  - mem_ack while mem_req=0 is ignored.
  - Unbounded wait is allowed.
- RESP: resp_valid=1 for exactly one cycle, then -> IDLE. req_ready=0 in every state except IDLE, so there is no back-to-back accept in RESP.
- Write policy, default (write-through, no-write-allocate):
  - Write hit updates the line and LRU.
  - Write miss leaves the cache untouched.
  - Both go to MEMWR (mem_rw=1, addr/data latched); on mem_ack -> RESP with resp_hit = hit.
- EVICT is unreachable in the default build.

Optional Feature:
- Macro: ASSOC_CACHE_WRITE_BACK_EN.
- Defined:
  - Per-way dirty bit, reset 0.
  - Write hit updates the line, sets dirty, no memory access, -> RESP (latency 2).
  - Write miss allocates the victim (no fill, line = one word).
  - Read miss with a dirty victim first passes through EVICT: mem write of victim tag/data, clear dirty on ack, then FILL.
  - Write miss with a dirty victim: EVICT, then allocate with dirty=1, -> RESP.
  - Clean victims skip EVICT.
- Undefined: write-through behaviour as above; no dirty storage.

Test Plan:
- Reset then read 0x01 (mem returns 0xE0 after 3 cycles) -> one mem read at 0x01; resp_rdata=0xE0, resp_hit=0. A repeat read gives resp_hit=1, 0xE0, latency 2, no mem_req.
- Fill 0x01, 0x02, 0x03, 0x04, re-read 0x01, then read 0x07 -> 0x02 evicted (lru_way=1 before miss); a subsequent read of 0x02 misses, 0x01 hits.
- Default build, write 0x05=0x18 (miss) -> mem write 0x05/0x18, resp_hit=0; read 0x05 still misses. Write to a cached 0x01=0xC7 -> mem write plus cache update; read 0x01 hits 0xC7.
- WRITE_BACK_EN: write 0x01..0x04 (no mem traffic), then read 0x08 -> EVICT writes 0x01's data first, then FILL 0x08.
- mem_ack delayed 10 cycles with clr pulsed at cycle 5 -> mem_req=0 immediately; all lines invalid; req_ready=1; no resp_valid.
- Hold mem_ack high continuously while idle -> no state change, no resp_valid.
